pixel_state: RTL and testbench

//  Frame-sequencing controller for the pixel sensor array (2x2 pixels sharing one 8-bit data bus).

---
 rtl/pixel_state_if.sv | 14 +
 rtl/pixel_state.sv | 92 +++++++++
 tb/tb_pixel_state.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_state_if.sv
// Control pins from the frame sequencer to the 2x2 pixel array and ADC ramp.
// The master modport drives the pins; the slave modport observes them.
interface pixel_state_if;
  logic erase;
  logic expose;
  logic convert;
  logic read;
  logic read2;
  logic read3;
  logic read4;

  modport master (output erase, expose, convert, read, read2, read3, read4);
  modport slave  (input  erase, expose, convert, read, read2, read3, read4);
endinterface

// File: rtl/pixel_state.sv
// Frame sequencer for a 2x2 pixel array: erase -> expose -> convert -> read 1..4, free-running.
// Moore FSM with a 16-bit dwell counter; every control pin is a registered decode of the state.
module pixel_state #(
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5
) (
  input  logic           clk,
  input  logic           reset,
  pixel_state_if.master  pix
);

  // A zero dwell is illegal; treat it as a single-cycle state.
  localparam logic [15:0] ERASE_LAST   = 16'((C_ERASE   == 0) ? 0 : C_ERASE   - 1);
  localparam logic [15:0] EXPOSE_LAST  = 16'((C_EXPOSE  == 0) ? 0 : C_EXPOSE  - 1);
  localparam logic [15:0] CONVERT_LAST = 16'((C_CONVERT == 0) ? 0 : C_CONVERT - 1);
  localparam logic [15:0] READ_LAST    = 16'((C_READ    == 0) ? 0 : C_READ    - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ1   = 3'd4,
    READ2   = 3'd5,
    READ3   = 3'd6,
    READ4   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // {erase, expose, convert, read, read2, read3, read4}
  logic [6:0]  out_q, out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;

    case (state_q)
      IDLE:    state_d = ERASE;
      ERASE:   if (cnt_q == ERASE_LAST)   state_d = EXPOSE;
      EXPOSE:  if (cnt_q == EXPOSE_LAST)  state_d = CONVERT;
      CONVERT: if (cnt_q == CONVERT_LAST) state_d = READ1;
      READ1:   if (cnt_q == READ_LAST)    state_d = READ2;
      READ2:   if (cnt_q == READ_LAST)    state_d = READ3;
      READ3:   if (cnt_q == READ_LAST)    state_d = READ4;
      READ4:   if (cnt_q == READ_LAST)    state_d = ERASE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end

    // Outputs are registered from the next state so each pin mirrors state_q without decode glitches.
    case (state_d)
      ERASE:   out_d = 7'b1000000;
      EXPOSE:  out_d = 7'b0100000;
      CONVERT: out_d = 7'b0010000;
      READ1:   out_d = 7'b0001000;
      READ2:   out_d = 7'b0000100;
      READ3:   out_d = 7'b0000010;
      READ4:   out_d = 7'b0000001;
      default: out_d = 7'b0000000;
    endcase
  end

  assign pix.erase   = out_q[6];
  assign pix.expose  = out_q[5];
  assign pix.convert = out_q[4];
  assign pix.read    = out_q[3];
  assign pix.read2   = out_q[2];
  assign pix.read3   = out_q[1];
  assign pix.read4   = out_q[0];

endmodule

// File: tb/tb_pixel_state.sv
// Directed bench for the pixel frame sequencer: default and short-dwell instances share clk/reset.
// Outputs are sampled on the falling edge; sample 0 after reset release is the single IDLE cycle.
module tb_pixel_state;

  logic clk;
  logic reset;

  pixel_state_if pif ();
  pixel_state_if pif_s ();

  pixel_state dut (
    .clk   (clk),
    .reset (reset),
    .pix   (pif)
  );

  pixel_state #(.C_ERASE(1), .C_EXPOSE(255), .C_CONVERT(255), .C_READ(1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .pix   (pif_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] vd, vs;
  assign vd = {pif.erase, pif.expose, pif.convert, pif.read, pif.read2, pif.read3, pif.read4};
  assign vs = {pif_s.erase, pif_s.expose, pif_s.convert, pif_s.read, pif_s.read2, pif_s.read3, pif_s.read4};

  // Pixel 1 model: ramp counts 0.. during convert; pixel at 0.7 of full scale latches 178 (0.7*255 truncated).
  localparam logic [7:0] THR = 8'd178;
  logic [7:0] ramp, pix_v, bus;
  logic       latched;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp <= 8'd0; pix_v <= 8'd0; latched <= 1'b0;
    end else begin
      if (pif.convert) ramp <= ramp + 8'd1;
      else             ramp <= 8'd0;
      if (pif.erase) latched <= 1'b0;
      else if (pif.convert && !latched && ramp >= THR) begin
        pix_v <= ramp; latched <= 1'b1;
      end
    end
  end
  assign bus = pif.read ? pix_v : 8'd0;

  // Expected pin vector k samples after reset release (k=0 is IDLE).
  function automatic logic [6:0] model(int k, int ce, int cx, int cc, int cr);
    int p;
    if (k == 0) return 7'b0;
    p = (k - 1) % (ce + cx + cc + 4 * cr);
    if (p < ce) return 7'b1000000;
    p -= ce;
    if (p < cx) return 7'b0100000;
    p -= cx;
    if (p < cc) return 7'b0010000;
    p -= cc;
    return 7'b0001000 >> (p / cr);
  endfunction

  // Assert reset for n cycles, release 2 time units after a rising edge.
  task automatic do_reset(int n);
    @(posedge clk); #2 reset = 1'b0;
    repeat (n) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    n_cmp++;
    if (vd !== 7'b0 || vs !== 7'b0) begin
      n_bad++; $display("FAIL reset_state: got %b/%b want 0000000", vd, vs);
    end
  endtask

  task automatic test_reset_mid_expose;
    do_reset(2);
    for (int k = 0; k < 100; k++) @(negedge clk);
    n_cmp++;
    if (vd !== 7'b0100000) begin
      n_bad++; $display("FAIL pre_abort_expose: got %b want 0100000", vd);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (vd !== 7'b0 || clk !== 1'b0) begin
      n_bad++; $display("FAIL async_abort_expose: got %b clk %b want 0000000 clk 0", vd, clk);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vd !== 7'b0) begin
      n_bad++; $display("FAIL held_reset: got %b want 0000000", vd);
    end
    @(posedge clk); #2 reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vd !== model(k, 5, 255, 255, 5)) begin
        n_bad++; $display("FAIL restart_seq k=%0d: got %b want %b", k, vd, model(k, 5, 255, 255, 5));
      end
    end
  endtask

  // Two default frames plus margin: every sample against the model and one-hot-or-zero.
  task automatic test_free_run;
    do_reset(2);
    for (int k = 0; k < 1075; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vd !== model(k, 5, 255, 255, 5)) begin
        n_bad++; $display("FAIL default_seq k=%0d: got %b want %b", k, vd, model(k, 5, 255, 255, 5));
      end
      n_cmp++;
      if (!$onehot0(vd)) begin
        n_bad++; $display("FAIL onehot0 k=%0d: got %b want at most one bit", k, vd);
      end
    end
  endtask

  task automatic test_short_dwell;
    do_reset(2);
    for (int k = 0; k < 1035; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vs !== model(k, 1, 255, 255, 1)) begin
        n_bad++; $display("FAIL short_seq k=%0d: got %b want %b", k, vs, model(k, 1, 255, 255, 1));
      end
    end
  endtask

  task automatic test_pixel_capture;
    logic [7:0] got [2];
    int nf;
    logic prev_rd;
    nf = 0;
    prev_rd = 1'b0;
    got[0] = 8'hxx; got[1] = 8'hxx;
    do_reset(2);
    for (int k = 0; k < 1200 && nf < 2; k++) begin
      @(negedge clk);
      if (pif.read && !prev_rd) begin
        got[nf] = bus;
        nf++;
      end
      prev_rd = pif.read;
    end
    n_cmp++;
    if (nf != 2) begin
      n_bad++; $display("FAIL read_frames: got %0d read pulses want 2", nf);
    end
    for (int f = 0; f < 2; f++) begin
      n_cmp++;
      if (got[f] !== THR) begin
        n_bad++; $display("FAIL pixel_value f=%0d: got %0d want %0d", f, got[f], THR);
      end
    end
  endtask

  task automatic test_reset_in_read3;
    do_reset(2);
    for (int k = 0; k < 528; k++) @(negedge clk);
    n_cmp++;
    if (vd !== 7'b0000010) begin
      n_bad++; $display("FAIL pre_abort_read3: got %b want 0000010", vd);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (pif.read3 !== 1'b0 || vd !== 7'b0 || clk !== 1'b0) begin
      n_bad++; $display("FAIL async_abort_read3: got %b clk %b want 0000000 clk 0", vd, clk);
    end
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vd !== 7'b0) begin
      n_bad++; $display("FAIL idle_after_read3: got %b want 0000000", vd);
    end
    @(negedge clk);
    n_cmp++;
    if (vd !== 7'b1000000) begin
      n_bad++; $display("FAIL erase_after_read3: got %b want 1000000", vd);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_reset_mid_expose;
    test_free_run;
    test_short_dwell;
    test_pixel_capture;
    test_reset_in_read3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
